// File: rtl/flag_event_collector.sv
// Rising-edge collector for three status flags: saturating per-flag counters plus an event FIFO.
// Define FLAG_EVENT_COLLECTOR_TIMESTAMP_EN to keep an 8-bit timestamp per event; otherwise evt_ts is 0.
module flag_event_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       q,
    input  logic             clr,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_id,
    output logic [7:0]       evt_ts,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic             ovf
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = AW + 1;

    logic [2:0]       prev_q_reg;
    logic [2:0]       pending_reg;
    logic [2:0]       pending_next;
    logic [2:0]       rise;
    logic [2:0]       push_sel;
    logic [2:0]       lose;
    logic [1:0]       push_id;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             can_push;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [OW-1:0]    occ_reg;
    logic             ovf_reg;
    logic [1:0]       id_mem [DEPTH];
    logic [CNT_W-1:0] cnt_reg [3];

    assign rise     = q & ~prev_q_reg;
    assign empty    = (occ_reg == '0);
    assign full     = (occ_reg == OW'(DEPTH));
    assign pop      = ~empty & evt_ready;
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign can_push = ~full | pop;

    always_comb begin
        push_sel = 3'b000;
        push_id  = 2'd0;
        if (can_push) begin
            if (pending_reg[2]) begin
                push_sel = 3'b100;
                push_id  = 2'd2;
            end else if (pending_reg[1]) begin
                push_sel = 3'b010;
                push_id  = 2'd1;
            end else if (pending_reg[0]) begin
                push_sel = 3'b001;
                push_id  = 2'd0;
            end
        end
    end

    assign push = |push_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_flag
            // A fresh edge re-arms a bit that is being pushed; it is lost only if the bit stays set.
            assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~push_sel[gi]);
            assign lose[gi]         = rise[gi] & pending_reg[gi] & ~push_sel[gi];

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt_reg[gi] <= '0;
                end else if (rise[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q_reg  <= 3'b000;
            pending_reg <= 3'b000;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            occ_reg     <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            prev_q_reg  <= q;
            pending_reg <= pending_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
            if (clr) begin
                ovf_reg <= 1'b0;
            end else if (|lose) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr_reg] <= push_id;
        end
    end

    // Head is gated so stale storage never shows after reset or while empty.
    assign evt_valid = ~empty;
    assign evt_id    = empty ? 2'd0 : id_mem[rd_ptr_reg];

`ifdef FLAG_EVENT_COLLECTOR_TIMESTAMP_EN
    logic [7:0] ts_reg;
    logic [7:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_reg <= 8'd0;
        end else begin
            ts_reg <= ts_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr_reg] <= ts_reg;
        end
    end

    assign evt_ts = empty ? 8'd0 : ts_mem[rd_ptr_reg];
`else
    assign evt_ts = 8'd0;
`endif

    assign cnt_a = cnt_reg[2];
    assign cnt_b = cnt_reg[1];
    assign cnt_c = cnt_reg[0];
    assign ovf   = ovf_reg;
endmodule
